// File: rtl/alu_uart_frontend_pkg.sv
// Shared encodings and command layout for the ALU UART front end.
package alu_uart_frontend_pkg;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {M_IDLE, M_ISSUE, M_SETTLE, M_CAPTURE, M_SEND} main_state_t;

  // Command byte field positions (MSB of each field).
  localparam int A_MSB  = 7;
  localparam int B_MSB  = 5;
  localparam int OP_MSB = 3;

  // UART line level while idle / stop bit.
  localparam logic LINE_IDLE = 1'b1;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] op;
  } cmd_t;

  // Split a received command byte into ALU operand/opcode fields.
  function automatic cmd_t unpack_cmd(input logic [7:0] raw);
    cmd_t c;
    c.a  = raw[A_MSB -: 2];
    c.b  = raw[B_MSB -: 2];
    c.op = raw[OP_MSB -: 4];
    return c;
  endfunction

endpackage

// File: rtl/alu_uart_frontend_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, start-bit glitch filter,
// mid-bit sampling. Strobes are single-cycle and derived from registers.
module uart_rx_byte
  import alu_uart_frontend_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic          r_meta;
  logic          r_sync;
  logic          r_sync_d;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_half;
  logic          w_bit_end;
  logic          w_stop_sample;

  assign w_half        = (r_cnt == CW'(HALF - 1));
  assign w_bit_end     = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_stop_sample = (r_state == R_STOP) && w_bit_end;
  assign o_valid       = w_stop_sample && r_sync;
  assign o_frame_err   = w_stop_sample && !r_sync;
  assign o_data        = r_shift;

  // Bring rx into the clock domain; r_sync_d gives the falling-edge history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking (<=) so every flop updates from pre-edge values;
    // blocking here would collapse the synchronizer chain into one stage.
    if (i_rst) begin
      r_meta   <= LINE_IDLE;
      r_sync   <= LINE_IDLE;
      r_sync_d <= LINE_IDLE;
    end else begin
      r_meta   <= i_rx;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  // Receive FSM: detect start, confirm at half bit, shift 8 bits, sample stop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      unique case (r_state)
        R_IDLE: begin
          r_cnt <= '0;
          if (r_sync_d && !r_sync) r_state <= R_START;
        end
        R_START: if (w_half) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= r_sync ? R_IDLE : R_DATA;
        end
        R_DATA: if (w_bit_end) begin
          r_cnt   <= '0;
          r_shift <= {r_sync, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= R_STOP;
        end
        R_STOP: if (w_bit_end) begin
          r_cnt   <= '0;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_uart_frontend_tx.sv
// UART 8N1 transmitter with a registered line output.
module uart_tx_byte
  import alu_uart_frontend_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign o_done    = (r_state == T_STOP) && w_bit_end;
  assign o_tx      = r_tx;

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= T_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= LINE_IDLE;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      unique case (r_state)
        T_IDLE: begin
          r_cnt <= '0;
          if (i_start) begin
            r_shift <= i_data;
            r_tx    <= 1'b0;
            r_state <= T_START;
          end
        end
        T_START: if (w_bit_end) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_tx    <= r_shift[0];
          r_state <= T_DATA;
        end
        T_DATA: if (w_bit_end) begin
          r_cnt <= '0;
          if (r_bit == 3'd7) begin
            r_tx    <= LINE_IDLE;
            r_state <= T_STOP;
          end else begin
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
            r_bit   <= r_bit + 3'd1;
          end
        end
        T_STOP: if (w_bit_end) begin
          r_cnt   <= '0;
          r_state <= T_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_uart_frontend.sv
// Host-side serial front end for the 2-bit ALU: one command byte in,
// one result byte out, with a single-entry hold buffer between them.
module alu_uart_frontend
  import alu_uart_frontend_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 434,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  logic          w_rx_valid;
  logic [7:0]    w_rx_data;
  logic          w_rx_err;
  logic          w_tx_start;
  logic          w_tx_done;
  logic          w_pop;
  logic          r_buf_full;
  logic [7:0]    r_buf_data;
  logic          r_frame_err;
  logic          r_overrun;
  main_state_t   r_state;
  cmd_t          r_cmd;
  cmd_t          r_alu_cmd;
  logic          r_busy;
  logic [SW-1:0] r_settle;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .o_valid     (w_rx_valid),
    .o_data      (w_rx_data),
    .o_frame_err (w_rx_err)
  );

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (w_tx_start),
    .i_data  (alu_result),
    .o_tx    (tx),
    .o_done  (w_tx_done)
  );

  assign w_pop      = (r_state == M_IDLE) && r_buf_full;
  assign w_tx_start = (r_state == M_CAPTURE);
  assign alu_a      = r_alu_cmd.a;
  assign alu_b      = r_alu_cmd.b;
  assign alu_op     = r_alu_cmd.op;
  assign busy       = r_busy;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

  // Hold buffer: a same-cycle pop frees the slot for the incoming byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_full  <= 1'b0;
      r_buf_data  <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_rx_err;
      r_overrun   <= w_rx_valid && r_buf_full && !w_pop;
      if (w_rx_valid && (!r_buf_full || w_pop)) begin
        r_buf_data <= w_rx_data;
        r_buf_full <= 1'b1;
      end else if (w_pop) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  // Main sequencer: pop, drive ALU, let it settle, capture, wait for reply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= M_IDLE;
      r_cmd     <= '0;
      r_alu_cmd <= '0;
      r_busy    <= 1'b0;
      r_settle  <= '0;
    end else begin
      unique case (r_state)
        M_IDLE: if (w_pop) begin
          r_cmd   <= unpack_cmd(r_buf_data);
          r_state <= M_ISSUE;
        end
        M_ISSUE: begin
          r_alu_cmd <= r_cmd;
          r_busy    <= 1'b1;
          r_settle  <= '0;
          r_state   <= M_SETTLE;
        end
        M_SETTLE: begin
          if (r_settle == SW'(SETTLE_CYCLES - 1)) r_state <= M_CAPTURE;
          else                                    r_settle <= r_settle + SW'(1);
        end
        M_CAPTURE: r_state <= M_SEND;
        M_SEND: if (w_tx_done) begin
          r_busy  <= 1'b0;
          r_state <= M_IDLE;
        end
        default: r_state <= M_IDLE;
      endcase
    end
  end

endmodule
